hdu: RTL and testbench

- Hazard detection unit for the 5-stage MIPS pipeline; the stalling counterpart to the forwarding unit.
- Covers what forwarding cannot resolve: load-use hazards, and operands needed in ID by branches.
- Freezes PC and IF/ID, injects a bubble into ID/EX, and flushes IF/ID on taken branches.
- Registered FSM holds multi-cycle stalls so branch-after-load costs exactly 2 cycles.

---
 rtl/hdu_pkg.sv | 13 +
 rtl/hdu_perf_cnt.sv | 14 +
 rtl/hdu.sv | 58 +++++
 tb/tb_hdu.sv | 119 +++++++++++
 4 files changed

// File: rtl/hdu_pkg.sv
// hdu_pkg: shared types and hazard classification for the hazard detection unit
package hdu_pkg;
   typedef enum logic {IDLE, HOLD} hdu_state_t;
   typedef enum logic [1:0] {HZ_NONE, HZ_LU, HZ_BA, HZ_BL} hazard_t;
   localparam logic [4:0] REG_ZERO = 5'd0;
   function automatic hazard_t classify(input logic hit, input logic branch,
                                        input logic reg_write, input logic mem_read);
      return !hit                   ? HZ_NONE :
             (branch && mem_read)   ? HZ_BL   :
             (branch && reg_write)  ? HZ_BA   :
             (!branch && mem_read)  ? HZ_LU   : HZ_NONE;
   endfunction
endpackage

// File: rtl/hdu_perf_cnt.sv
// hdu_perf_cnt: saturating event counter cleared by asynchronous reset
module hdu_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);
   // count events, holding at all-ones
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hdu.sv
// hdu: load-use / branch-operand stall unit; HDU_PERF_EN enables stall and flush counters
module hdu
   import hdu_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_useRt,
   input  logic                  id_branch,
   input  logic                  id_branchTaken,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_regWrite,
   input  logic                  ex_memRead,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  idex_flush,
   output logic                  ifid_flush,
   output logic                  stall,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count
);
   hdu_state_t state, state_n;
   hazard_t    hz;
   logic       hit, stall_c, flush_taken;
   // classify the ID/EX dependency; HOLD forces the second cycle of a branch-after-load stall
   always_comb begin
      hit         = (ex_rd != REG_ADDR_W'(REG_ZERO)) &&
                    ((ex_rd == id_rs) || (id_useRt && (ex_rd == id_rt)));
      hz          = classify(hit, id_branch, ex_regWrite, ex_memRead);
      stall_c     = (state == HOLD) || (hz != HZ_NONE);
      flush_taken = !stall_c && id_branch && id_branchTaken;
      state_n     = (state == IDLE && hz == HZ_BL) ? HOLD : IDLE;
   end
   // state register; reset drops any pending second stall
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   assign pc_write   = !reset && !stall_c;
   assign ifid_write = !reset && !stall_c;
   assign idex_flush = reset || stall_c;
   assign ifid_flush = reset || flush_taken;
   assign stall      = reset || stall_c;
`ifdef HDU_PERF_EN
   hdu_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk(clk), .reset(reset), .inc(stall_c), .cnt(stall_cycles)
   );
   hdu_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk(clk), .reset(reset), .inc(flush_taken), .cnt(flush_count)
   );
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_hdu.sv
// tb_hdu: directed and randomized checks of hdu against a stall-count reference model
module tb_hdu;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
   logic        id_useRt = 1'b0, id_branch = 1'b0, id_branchTaken = 1'b0;
   logic        ex_regWrite = 1'b0, ex_memRead = 1'b0;
   logic        pc_write, ifid_write, idex_flush, ifid_flush, stall;
   logic [31:0] stall_cycles, flush_count;
   int          checks = 0, errors = 0;
   int          pend = 0, n_pend = 0;
   longint      sc = 0, fc = 0;
   bit          e_stall, e_flush, hit;

   hdu dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_useRt(id_useRt),
      .id_branch(id_branch), .id_branchTaken(id_branchTaken), .ex_rd(ex_rd),
      .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .pc_write(pc_write),
      .ifid_write(ifid_write), .idex_flush(idex_flush), .ifid_flush(ifid_flush),
      .stall(stall), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                        input logic br, input logic tk, input logic [4:0] rd,
                        input logic rw, input logic mr);
      id_rs = rs; id_rt = rt; id_useRt = use_rt; id_branch = br; id_branchTaken = tk;
      ex_rd = rd; ex_regWrite = rw; ex_memRead = mr;
   endtask

   // Reference: a hazard costs N stall cycles (load->branch 2, else 1); pend counts extra cycles owed.
   task automatic cyc(input string tag);
      logic [31:0] esc, efc;
      @(negedge clk);
      if (reset) begin
         pend = 0; sc = 0; fc = 0; n_pend = 0; e_stall = 1; e_flush = 1;
      end else begin
         hit = (ex_rd != 0) && (ex_rd == id_rs || (id_useRt && ex_rd == id_rt));
         if (pend > 0) begin e_stall = 1; n_pend = pend - 1; end
         else if (hit && id_branch && ex_memRead) begin e_stall = 1; n_pend = 1; end
         else if (hit && !id_branch && ex_memRead) begin e_stall = 1; n_pend = 0; end
         else if (hit && id_branch && ex_regWrite) begin e_stall = 1; n_pend = 0; end
         else begin e_stall = 0; n_pend = 0; end
         e_flush = !e_stall && id_branch && id_branchTaken;
      end
`ifdef HDU_PERF_EN
      esc = (sc > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(sc);
      efc = (fc > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(fc);
`else
      esc = 0; efc = 0;
`endif
      chk({tag, ".pc_write"},   32'(pc_write),   32'(!e_stall && !reset));
      chk({tag, ".ifid_write"}, 32'(ifid_write), 32'(!e_stall && !reset));
      chk({tag, ".idex_flush"}, 32'(idex_flush), 32'(e_stall));
      chk({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(e_flush));
      chk({tag, ".stall"},      32'(stall),      32'(e_stall));
      chk({tag, ".stall_cycles"}, stall_cycles, esc);
      chk({tag, ".flush_count"},  flush_count,  efc);
      @(posedge clk);
      if (!reset) begin
         pend = n_pend;
         sc += longint'(e_stall);
         fc += longint'(e_flush);
      end
      #1;
   endtask

   initial begin
      #3 reset = 1'b1;
      cyc("rst_held");
      reset = 1'b0;
      cyc("rst_release");
      drive(5'd5, 5'd0, 0, 0, 0, 5'd5, 1, 1);
      cyc("lu_stall");
      drive(5'd5, 5'd0, 0, 0, 0, 5'd5, 1, 0);
      cyc("lu_after");
      drive(5'd1, 5'd2, 1, 1, 1, 5'd2, 1, 0);
      cyc("ba_stall");
      drive(5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0);
      cyc("ba_taken");
      drive(5'd8, 5'd0, 1, 1, 0, 5'd8, 1, 1);
      cyc("bl_stall1");
      drive(5'd8, 5'd0, 1, 1, 0, 5'd8, 1, 0);
      cyc("bl_stall2");
      cyc("bl_after");
      drive(5'd0, 5'd0, 1, 0, 0, 5'd0, 1, 1);
      cyc("zero_ld");
      drive(5'd0, 5'd0, 1, 1, 1, 5'd0, 1, 1);
      cyc("zero_br");
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
               1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom));
         cyc("rand");
      end
      reset = 1'b0;
      drive(5'd8, 5'd0, 1, 1, 0, 5'd8, 1, 1);
      cyc("hold_pre");
      reset = 1'b1;
      cyc("hold_rst");
      reset = 1'b0;
      drive(5'd8, 5'd0, 1, 1, 0, 5'd8, 1, 0);
      cyc("hold_released");
      drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
      cyc("hold_idle");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
